// File: rtl/pref_pkg.sv
// Shared types and helpers for the prefetch issue queue.
package pref_pkg;

  localparam int ADDR_W      = 64;
  localparam int LINE_OFFSET = 6;

  typedef logic [ADDR_W-1:0] line_addr_t;

  typedef struct packed {
    logic       valid;
    line_addr_t addr;
  } cand_t;

  function automatic line_addr_t line_align(input logic [ADDR_W-1:0] a);
    line_align = {a[ADDR_W-1:LINE_OFFSET], {LINE_OFFSET{1'b0}}};
  endfunction

endpackage

// File: rtl/pref_dedup.sv
// Flags each candidate that repeats an earlier slot or any live queue entry.
module pref_dedup
  import pref_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  cand_t      [2:0]       cand,
  input  line_addr_t [DEPTH-1:0] entries,
  input  logic       [DEPTH-1:0] entry_valid,
  output logic       [2:0]       keep,
  output logic       [1:0]       dup_cnt
);

  logic [2:0] hit_s;

  // Match every slot against lower slots and valid queue entries.
  always_comb begin
    keep    = 3'b000;
    dup_cnt = 2'd0;
    hit_s   = 3'b000;
    for (int k = 0; k < 3; k++) begin
      for (int j = 0; j < 3; j++) begin
        if ((j < k) && cand[j].valid && (cand[j].addr == cand[k].addr)) begin
          hit_s[k] = 1'b1;
        end else begin
          hit_s[k] = hit_s[k];
        end
      end
      for (int e = 0; e < DEPTH; e++) begin
        if (entry_valid[e] && (entries[e] == cand[k].addr)) begin
          hit_s[k] = 1'b1;
        end else begin
          hit_s[k] = hit_s[k];
        end
      end
      if (cand[k].valid && hit_s[k]) begin
        dup_cnt = dup_cnt + 2'd1;
      end else if (cand[k].valid) begin
        keep[k] = 1'b1;
      end else begin
        keep[k] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/pref_issue_queue.sv
// Prefetch issue scheduler: aligns, dedups and buffers up to three candidates
// per cycle, issuing one line request per cycle over valid/ready.
module pref_issue_queue
  import pref_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [ADDR_W-1:0]          pref_addr1_i,
  input  logic                       pref_valid1_i,
  input  logic [ADDR_W-1:0]          pref_addr2_i,
  input  logic                       pref_valid2_i,
  input  logic [ADDR_W-1:0]          pref_addr3_i,
  input  logic                       pref_valid3_i,
  input  logic                       flush_i,
  output logic [ADDR_W-1:0]          req_addr_o,
  output logic                       req_valid_o,
  input  logic                       req_ready_i,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic [CNT_W-1:0]           drop_cnt_o,
  output logic [CNT_W-1:0]           dup_cnt_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CW    = PTR_W + 1;

  line_addr_t [DEPTH-1:0] mem_r;
  logic [PTR_W-1:0]       rd_ptr_r, wr_ptr_r;
  logic [CW-1:0]          count_r;

  cand_t [2:0]            cand_s;
  logic [DEPTH-1:0]       entry_valid_s;
  logic [2:0]             keep_s, acc_s;
  logic [1:0]             dup_n_s, drop_n_s;
  logic [PTR_W-1:0]       wr_off_s [3];
  logic [PTR_W-1:0]       off_s, rd_next_s;
  logic [CW-1:0]          free_s, enq_s, count_next_s;
  logic                   deq_s;
  line_addr_t             first_addr_s, head_next_s;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {{(CNT_W-1){1'b0}}, b};
    sat_add = s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  // Align candidates and mark which FIFO slots hold live entries.
  always_comb begin
    cand_s[0] = {pref_valid1_i, line_align(pref_addr1_i)};
    cand_s[1] = {pref_valid2_i, line_align(pref_addr2_i)};
    cand_s[2] = {pref_valid3_i, line_align(pref_addr3_i)};
    off_s     = '0;
    for (int e = 0; e < DEPTH; e++) begin
      off_s            = PTR_W'(e) - rd_ptr_r;
      entry_valid_s[e] = ({1'b0, off_s} < count_r);
    end
  end

  pref_dedup #(.DEPTH(DEPTH)) u_dedup (
    .cand        (cand_s),
    .entries     (mem_r),
    .entry_valid (entry_valid_s),
    .keep        (keep_s),
    .dup_cnt     (dup_n_s)
  );

  // Compact survivors into free slots; overflow drops the highest slots.
  always_comb begin
    free_s   = CW'(DEPTH) - count_r;
    enq_s    = '0;
    acc_s    = 3'b000;
    drop_n_s = 2'd0;
    for (int k = 0; k < 3; k++) begin
      wr_off_s[k] = '0;
      if (keep_s[k] && (enq_s < free_s)) begin
        acc_s[k]    = 1'b1;
        wr_off_s[k] = enq_s[PTR_W-1:0];
        enq_s       = enq_s + CW'(1);
      end else if (keep_s[k]) begin
        drop_n_s = drop_n_s + 2'd1;
      end else begin
        acc_s[k] = 1'b0;
      end
    end
  end

  // Next head: the oldest remaining entry, or the first new one if none remain.
  always_comb begin
    deq_s        = req_valid_o & req_ready_i;
    count_next_s = count_r + enq_s - CW'(deq_s);
    rd_next_s    = rd_ptr_r + PTR_W'(deq_s);
    if (acc_s[0]) begin
      first_addr_s = cand_s[0].addr;
    end else if (acc_s[1]) begin
      first_addr_s = cand_s[1].addr;
    end else if (acc_s[2]) begin
      first_addr_s = cand_s[2].addr;
    end else begin
      first_addr_s = '0;
    end
    if ((count_r - CW'(deq_s)) == '0) begin
      head_next_s = first_addr_s;
    end else begin
      head_next_s = mem_r[rd_next_s];
    end
  end

  // Queue state, statistics and registered request outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_r    <= '0;
      wr_ptr_r    <= '0;
      count_r     <= '0;
      req_valid_o <= 1'b0;
      req_addr_o  <= '0;
      drop_cnt_o  <= '0;
      dup_cnt_o   <= '0;
    end else if (flush_i) begin
      rd_ptr_r    <= '0;
      wr_ptr_r    <= '0;
      count_r     <= '0;
      req_valid_o <= 1'b0;
      req_addr_o  <= '0;
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (acc_s[k]) begin
          mem_r[wr_ptr_r + wr_off_s[k]] <= cand_s[k].addr;
        end
      end
      rd_ptr_r    <= rd_next_s;
      wr_ptr_r    <= wr_ptr_r + enq_s[PTR_W-1:0];
      count_r     <= count_next_s;
      req_valid_o <= (count_next_s != '0);
      req_addr_o  <= (count_next_s != '0) ? head_next_s : '0;
      drop_cnt_o  <= sat_add(drop_cnt_o, drop_n_s);
      dup_cnt_o   <= sat_add(dup_cnt_o, dup_n_s);
    end
  end

  assign count_o = count_r;

endmodule
